// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: default width,
// FSM state encoding and iteration counter width.
package iter_divider_pkg;

   localparam int WIDTH_DEF = 32;

   localparam int CNT_W = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } divState_t;

endpackage

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor on a WIDTH+1 bit remainder, keep if non-negative.
module div_step
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      // A clear top bit means the subtraction did not borrow.
      if (!trial[WIDTH]) begin
         rem_out = trial[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divider with start/busy/done handshake;
// magnitudes are divided unsigned and signs are restored on entry to DONE.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             DIV_clk,
   input  logic             DIV_rst,
   input  logic             DIV_ena,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CntW = (WIDTH == WIDTH_DEF) ? CNT_W : $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   divState_t        state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             signQ_q, signQ_d;
   logic             signR_q, signR_d;
   logic [WIDTH-1:0] qOut_q, qOut_d;
   logic [WIDTH-1:0] rOut_q, rOut_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] stepRem;
   logic [WIDTH-1:0] stepQuo;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvsr_q),
      .rem_out (stepRem),
      .quo_out (stepQuo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      signQ_d = signQ_q;
      signR_d = signR_q;
      qOut_d  = qOut_q;
      rOut_d  = rOut_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               quo_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
               dvsr_d  = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
               signQ_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               signR_d = is_signed & dividend[WIDTH-1];
               rem_d   = '0;
               cnt_d   = '0;
               if (divisor == '0) begin
                  state_d = DONE;
                  qOut_d  = '1;
                  rOut_d  = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            rem_d = stepRem;
            quo_d = stepQuo;
            // The final step's result goes straight into the output registers.
            if (cnt_q == LastCnt) begin
               state_d = DONE;
               qOut_d  = signQ_q ? -stepQuo : stepQuo;
               rOut_d  = signR_q ? -stepRem : stepRem;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge DIV_clk) begin
      if (DIV_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         signQ_q <= 1'b0;
         signR_q <= 1'b0;
         qOut_q  <= '0;
         rOut_q  <= '0;
         dbz_q   <= 1'b0;
      end else if (DIV_ena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         signQ_q <= signQ_d;
         signR_q <= signR_d;
         qOut_q  <= qOut_d;
         rOut_q  <= rOut_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign q           = qOut_q;
   assign r           = rOut_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: expected results are queued when an
// operation is started and compared when done rises.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b1;
   logic        start = 1'b0;
   logic        isSigned = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        divByZero;

   int checks = 0;
   int failures = 0;
   int edgeCount = 0;
   int startEdge = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   iter_divider #(.WIDTH(32)) dut (
      .DIV_clk     (clk),
      .DIV_rst     (rst),
      .DIV_ena     (ena),
      .start       (start),
      .is_signed   (isSigned),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (divByZero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   // busy and done must never be high together
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_with_done busy=%b required=0", busy);
         end
      end
   end

   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  input int lat);
      exp_t   e;
      longint da, db, qq, rr;
      if (b == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         if (s) begin
            da = longint'($signed(a));
            db = longint'($signed(b));
         end else begin
            da = longint'({32'd0, a});
            db = longint'({32'd0, b});
         end
         qq    = da / db;
         rr    = da % db;
         e.q   = qq[31:0];
         e.r   = rr[31:0];
         e.dbz = 1'b0;
         e.lat = lat;
      end
      return e;
   endfunction

   // Called at a negedge; start is high across exactly one rising edge.
   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input int lat);
      start    = 1'b1;
      isSigned = s;
      dividend = a;
      divisor  = b;
      sb.push_back(model(s, a, b, lat));
      @(negedge clk);
      startEdge = edgeCount;
      start     = 1'b0;
   endtask

   task automatic waitDone(output int lat);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      lat = (done === 1'b1) ? (edgeCount - startEdge + 1) : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, divByZero} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_flags busy/done/dbz=%b required=000", {busy, done, divByZero});
      end
      checks++;
      if ({q, r} !== 64'd0) begin
         failures++;
         $display("[TB] FAIL reset_data q=%h r=%h required 0/0", q, r);
      end
   endtask

   task automatic test_unsigned();
      exp_t e;
      int   lat;
      applyStimulus(1'b0, 32'd100, 32'd7, 33);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_after_start busy=%b required=1", busy);
      end
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
         failures++;
         $display("[TB] FAIL unsigned_latency got=%0d required=%0d", lat, e.lat);
      end
      checks++;
      if ({q, r, divByZero} !== {e.q, e.r, e.dbz}) begin
         failures++;
         $display("[TB] FAIL unsigned_100_7 q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                  q, r, divByZero, e.q, e.r, e.dbz);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, q, r} !== {1'b0, 32'd14, 32'd2}) begin
         failures++;
         $display("[TB] FAIL idle_hold done=%b q=%h r=%h required done=0 q=e r=2", done, q, r);
      end
   endtask

   task automatic test_signed();
      exp_t        e;
      int          lat;
      logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic        ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(ss[i], as[i], bs[i], 33);
         waitDone(lat);
         e = sb.pop_front();
         checks++;
         if (lat !== e.lat) begin
            failures++;
            $display("[TB] FAIL signed_latency case=%0d got=%0d required=%0d", i, lat, e.lat);
         end
         checks++;
         if ({q, r, divByZero} !== {e.q, e.r, e.dbz}) begin
            failures++;
            $display("[TB] FAIL signed_case%0d q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                     i, q, r, divByZero, e.q, e.r, e.dbz);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      applyStimulus(1'b0, 32'd5, 32'd0, 1);
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
         failures++;
         $display("[TB] FAIL dbz_latency got=%0d required=%0d", lat, e.lat);
      end
      checks++;
      if ({q, r, divByZero} !== {e.q, e.r, e.dbz}) begin
         failures++;
         $display("[TB] FAIL div_by_zero q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                  q, r, divByZero, e.q, e.r, e.dbz);
      end
      applyStimulus(1'b0, 32'd9, 32'd3, 33);
      checks++;
      if ({done, busy} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL b2b_done_falls done/busy=%b required=01", {done, busy});
      end
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if ({q, r, divByZero, lat} !== {e.q, e.r, e.dbz, e.lat}) begin
         failures++;
         $display("[TB] FAIL b2b_9_3 q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b lat=%0d",
                  q, r, divByZero, lat, e.q, e.r, e.dbz, e.lat);
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int   lat;
      bit   sawDone = 1'b0;
      applyStimulus(1'b0, 32'd100, 32'd7, 33);
      void'(sb.pop_back());
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, divByZero, q, r} !== 67'd0) begin
         failures++;
         $display("[TB] FAIL midrun_reset busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                  busy, done, divByZero, q, r);
      end
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      checks++;
      if (sawDone !== 1'b0) begin
         failures++;
         $display("[TB] FAIL aborted_no_done saw_done=%b required=0", sawDone);
      end
      applyStimulus(1'b0, 32'd100, 32'd7, 33);
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if ({q, r, divByZero, lat} !== {e.q, e.r, e.dbz, e.lat}) begin
         failures++;
         $display("[TB] FAIL after_reset_100_7 q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b lat=%0d",
                  q, r, divByZero, lat, e.q, e.r, e.dbz, e.lat);
      end
   endtask

   task automatic test_start_ignored();
      exp_t e;
      int   lat;
      applyStimulus(1'b0, 32'd1000, 32'd10, 33);
      repeat (4) @(negedge clk);
      start    = 1'b1;
      isSigned = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd5;
      @(negedge clk);
      start = 1'b0;
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if ({q, r, divByZero, lat} !== {e.q, e.r, e.dbz, e.lat}) begin
         failures++;
         $display("[TB] FAIL start_in_run q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b lat=%0d",
                  q, r, divByZero, lat, e.q, e.r, e.dbz, e.lat);
      end
   endtask

   task automatic test_enable_stall();
      exp_t e;
      int   lat;
      applyStimulus(1'b0, 32'd12345, 32'd67, 38);
      repeat (8) @(negedge clk);
      ena = 1'b0;
      repeat (5) @(negedge clk);
      ena = 1'b1;
      waitDone(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
         failures++;
         $display("[TB] FAIL stall_latency got=%0d required=%0d", lat, e.lat);
      end
      checks++;
      if ({q, r, divByZero} !== {e.q, e.r, e.dbz}) begin
         failures++;
         $display("[TB] FAIL stall_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                  q, r, divByZero, e.q, e.r, e.dbz);
      end
      ena = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({done, q} !== {1'b1, e.q}) begin
         failures++;
         $display("[TB] FAIL frozen_done done=%b q=%h required done=1 q=%h", done, q, e.q);
      end
      ena = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_release done=%b required=0", done);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_reset_mid_run();
      test_start_ignored();
      test_enable_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
